comp_2_table_writer: RTL and testbench

Sequential writer/server for the 2-bit comparator lookup table. After reset it sweeps a 16 x 4 RAM and writes the comparator word for every `{A1,A0,B1,B0}` address, one word per clock. It then serves registered compare lookups through a valid/ready handshake and accepts single-word overwrites. It replaces the simulation-only file load of the comparator table with synthesizable table generation, and sits between the control logic and any comparator-table consumer.

---
 rtl/comp_2_table_writer_pkg.sv | 17 +
 rtl/comp_2_ram_16x4.sv | 26 ++
 rtl/comp_2_table_writer.sv | 122 ++++++++++++
 tb/tb_comp_2_table_writer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/comp_2_table_writer_pkg.sv
// Shared constants and types for the 2-bit comparator lookup table.
package comp_2_table_writer_pkg;

    localparam int unsigned CMP_DEPTH = 16;
    localparam int unsigned CMP_WIDTH = 4;

    // Bit positions of the flags inside a table word; bit 0 is always zero.
    localparam int unsigned CMP_GT = 3;
    localparam int unsigned CMP_LT = 2;
    localparam int unsigned CMP_EQ = 1;

    typedef enum logic {
        S_LOAD  = 1'b0,
        S_READY = 1'b1
    } cmp_state_t;

endpackage : comp_2_table_writer_pkg

// File: rtl/comp_2_ram_16x4.sv
// Table storage: synchronous write, asynchronous read, no reset on contents.
module comp_2_ram_16x4 #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Single write port, updated on the clock edge.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Combinational read returns the pre-edge word, giving read-before-write.
    assign o_rdata = r_mem[i_raddr];

endmodule : comp_2_ram_16x4

// File: rtl/comp_2_table_writer.sv
// Sweeps the comparator table into RAM after reset, then serves lookups
// through a valid/ready handshake and accepts single-word overwrites.
module comp_2_table_writer
    import comp_2_table_writer_pkg::*;
#(
    parameter int unsigned DEPTH = CMP_DEPTH,
    parameter int unsigned WIDTH = CMP_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               A,
    input  logic [1:0]               B,
    output logic                     rsp_valid,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     A_gt_B,
    output logic                     A_lt_B,
    output logic                     A_eq_B,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     load_done
);

    localparam int unsigned AW = $clog2(DEPTH);

    cmp_state_t       r_state;
    logic [AW-1:0]    r_load_addr;
    logic             r_req_ready;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_load_done;

    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic [WIDTH-1:0] w_wdata;
    logic [AW-1:0]    w_raddr;
    logic [WIDTH-1:0] w_rdata;
    logic             w_fire;

    // Comparator word for address {a[1:0], b[1:0]}; exactly one flag set.
    function automatic logic [WIDTH-1:0] gen(input logic [AW-1:0] addr);
        logic [1:0] a;
        logic [1:0] b;
        gen = '0;
        a   = addr[3:2];
        b   = addr[1:0];
        if (a > b) begin
            gen[CMP_GT] = 1'b1;
        end else if (a < b) begin
            gen[CMP_LT] = 1'b1;
        end else begin
            gen[CMP_EQ] = 1'b1;
        end
    endfunction

    assign w_raddr = {A, B};
    assign w_fire  = req_valid && r_req_ready;

    // Write-port mux: the sweep owns the port in LOAD, the external port in READY.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_load_addr;
        w_wdata = gen(r_load_addr);
        if (!reset) begin
            if (r_state == S_LOAD) begin
                w_we = 1'b1;
            end else begin
                w_we    = wr_en;
                w_waddr = wr_addr;
                w_wdata = wr_data;
            end
        end
    end

    comp_2_ram_16x4 #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_ram (
        .i_clk   (clock),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // Sweep/serve FSM with registered handshake and response outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_LOAD;
            r_load_addr <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_load_done <= 1'b0;
        end else if (r_state == S_LOAD) begin
            r_load_addr <= r_load_addr + AW'(1);
            r_rsp_valid <= 1'b0;
            if (r_load_addr == AW'(DEPTH - 1)) begin
                r_state     <= S_READY;
                r_req_ready <= 1'b1;
                r_load_done <= 1'b1;
            end
        end else begin
            r_rsp_valid <= w_fire;
            if (w_fire) begin
                r_rsp_data <= w_rdata;
            end
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign load_done = r_load_done;
    assign A_gt_B    = r_rsp_data[CMP_GT];
    assign A_lt_B    = r_rsp_data[CMP_LT];
    assign A_eq_B    = r_rsp_data[CMP_EQ];

endmodule : comp_2_table_writer

// File: tb/tb_comp_2_table_writer.sv
// Directed bench for comp_2_table_writer: sweep timing, lookups, overwrites, mid-sweep reset.
module tb_comp_2_table_writer;

    logic       clock = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] A;
    logic [1:0] B;
    logic       rsp_valid;
    logic [3:0] rsp_data;
    logic       A_gt_B;
    logic       A_lt_B;
    logic       A_eq_B;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [3:0] wr_data;
    logic       load_done;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       rv;
        logic [1:0] a;
        logic [1:0] b;
        logic       we;
        logic [3:0] wa;
        logic [3:0] wd;
        logic       ev;
        logic [3:0] ed;
    } vec_t;

    vec_t vecs[$];

    comp_2_table_writer dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .A         (A),
        .B         (B),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .A_gt_B    (A_gt_B),
        .A_lt_B    (A_lt_B),
        .A_eq_B    (A_eq_B),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .load_done (load_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_rsp(input string tag, input logic ev, input logic [3:0] ed);
        chk({tag, " rsp_valid"}, {3'b0, rsp_valid}, {3'b0, ev});
        chk({tag, " rsp_data"}, rsp_data, ed);
        chk({tag, " flags"}, {1'b0, A_gt_B, A_lt_B, A_eq_B}, {1'b0, ed[3:1]});
    endtask

    // 16 sweep clocks: nothing ready until edge 16, no response at any point.
    task automatic sweep_check(input string tag);
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk($sformatf("%s sweep%0d rsp_valid", tag, k), {3'b0, rsp_valid}, 4'd0);
            chk($sformatf("%s sweep%0d rsp_data", tag, k), rsp_data, 4'd0);
            if (k < 16) begin
                chk($sformatf("%s sweep%0d load_done", tag, k), {3'b0, load_done}, 4'd0);
                chk($sformatf("%s sweep%0d req_ready", tag, k), {3'b0, req_ready}, 4'd0);
            end else begin
                chk($sformatf("%s sweep%0d load_done", tag, k), {3'b0, load_done}, 4'd1);
                chk($sformatf("%s sweep%0d req_ready", tag, k), {3'b0, req_ready}, 4'd1);
            end
        end
    endtask

    function automatic vec_t mk(input logic rv, input logic [1:0] a, input logic [1:0] b,
                                input logic we, input logic [3:0] wa, input logic [3:0] wd,
                                input logic ev, input logic [3:0] ed);
        vec_t v;
        v.rv = rv; v.a = a; v.b = b; v.we = we; v.wa = wa; v.wd = wd; v.ev = ev; v.ed = ed;
        return v;
    endfunction

    initial begin
        vec_t       v;
        logic [3:0] exp_w;

        // Lookup-phase vectors, expected words worked out by hand.
        vecs.push_back(mk(1'b1, 2'd0, 2'd0, 1'b0, 4'h0, 4'h0, 1'b1, 4'b0010)); // ext write during LOAD ignored
        vecs.push_back(mk(1'b1, 2'd2, 2'd1, 1'b0, 4'h0, 4'h0, 1'b1, 4'b1000));
        vecs.push_back(mk(1'b0, 2'd0, 2'd0, 1'b0, 4'h0, 4'h0, 1'b0, 4'b1000)); // hold
        vecs.push_back(mk(1'b1, 2'd1, 2'd3, 1'b0, 4'h0, 4'h0, 1'b1, 4'b0100));
        vecs.push_back(mk(1'b1, 2'd3, 2'd3, 1'b0, 4'h0, 4'h0, 1'b1, 4'b0010));
        vecs.push_back(mk(1'b1, 2'd0, 2'd0, 1'b0, 4'h0, 4'h0, 1'b1, 4'b0010));
        // All 16 pairs against an integer compare.
        for (int i = 0; i < 16; i++) begin
            int ia;
            int ib;
            ia = i / 4;
            ib = i % 4;
            exp_w = (ia > ib) ? 4'b1000 : ((ia < ib) ? 4'b0100 : 4'b0010);
            vecs.push_back(mk(1'b1, 2'(ia), 2'(ib), 1'b0, 4'h0, 4'h0, 1'b1, exp_w));
        end
        vecs.push_back(mk(1'b0, 2'd1, 2'd1, 1'b0, 4'h0, 4'h0, 1'b0, 4'b0010)); // hold after 3,3
        // Same-cycle lookup + overwrite of 4'b1001: old word returned, new word next time.
        vecs.push_back(mk(1'b1, 2'd2, 2'd1, 1'b1, 4'b1001, 4'b0001, 1'b1, 4'b1000));
        vecs.push_back(mk(1'b1, 2'd2, 2'd1, 1'b0, 4'h0, 4'h0, 1'b1, 4'b0001));
        vecs.push_back(mk(1'b1, 2'd1, 2'd2, 1'b0, 4'h0, 4'h0, 1'b1, 4'b0100));
        // Write without request, then read back.
        vecs.push_back(mk(1'b0, 2'd0, 2'd0, 1'b1, 4'b1111, 4'b1110, 1'b0, 4'b0100));
        vecs.push_back(mk(1'b1, 2'd3, 2'd3, 1'b0, 4'h0, 4'h0, 1'b1, 4'b1110));

        // Reset with a request and an external write held throughout.
        reset     = 1'b1;
        req_valid = 1'b1;
        A         = 2'd2;
        B         = 2'd1;
        wr_en     = 1'b1;
        wr_addr   = 4'h0;
        wr_data   = 4'hF;
        tick();
        tick();
        chk("reset req_ready", {3'b0, req_ready}, 4'd0);
        chk("reset load_done", {3'b0, load_done}, 4'd0);
        chk_rsp("reset", 1'b0, 4'b0000);

        reset = 1'b0;
        sweep_check("first");
        req_valid = 1'b0;
        wr_en     = 1'b0;

        foreach (vecs[i]) begin
            v         = vecs[i];
            req_valid = v.rv;
            A         = v.a;
            B         = v.b;
            wr_en     = v.we;
            wr_addr   = v.wa;
            wr_data   = v.wd;
            tick();
            chk_rsp($sformatf("vec%0d", i), v.ev, v.ed);
        end
        req_valid = 1'b0;
        wr_en     = 1'b0;

        // Reset at clock 7 of the sweep, request held the whole time.
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        req_valid = 1'b1;
        A         = 2'd3;
        B         = 2'd0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("partial sweep%0d rsp_valid", k), {3'b0, rsp_valid}, 4'd0);
            chk($sformatf("partial sweep%0d load_done", k), {3'b0, load_done}, 4'd0);
        end
        reset = 1'b1;
        tick();
        chk("midreset load_done", {3'b0, load_done}, 4'd0);
        chk("midreset req_ready", {3'b0, req_ready}, 4'd0);
        chk_rsp("midreset", 1'b0, 4'b0000);
        reset = 1'b0;
        sweep_check("restart");
        tick();
        chk_rsp("post-restart 3,0", 1'b1, 4'b1000);
        A = 2'd2;
        B = 2'd1;
        tick();
        chk_rsp("post-restart 2,1 reswept", 1'b1, 4'b1000);
        A = 2'd3;
        B = 2'd3;
        tick();
        chk_rsp("post-restart 3,3 reswept", 1'b1, 4'b0010);
        req_valid = 1'b0;
        tick();
        chk_rsp("post-restart idle", 1'b0, 4'b0010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_comp_2_table_writer
